ro_meas_ctrl: RTL and testbench

Measurement sequencer for the ring-oscillator characterisation tile.
- Serially loads the oscillator configuration shift chain (shift_clk/shift_dta).
- Selects one of 8 clock sources and releases the oscillator/divider reset.
- Counts rising edges of the divided oscillator output over a fixed window of clk cycles and presents the count with a valid/ack handshake.
- Sits between the tile pins/host logic and the oscillator bank, replacing manual pin toggling.

---
 rtl/ro_meas_pkg.sv | 19 +
 rtl/ro_edge_counter.sv | 68 ++++++
 rtl/ro_meas_ctrl.sv | 164 ++++++++++++++++
 tb/tb_ro_meas_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ro_meas_pkg.sv
// Shared types and constants for the ring-oscillator measurement sequencer.
package ro_meas_pkg;

  localparam int SRC_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_MEASURE,
    ST_DONE
  } state_t;

  // Three clk cycles per config bit: data setup, shift_clk high, shift_clk low.
  localparam logic [1:0] PH_SETUP = 2'd0;
  localparam logic [1:0] PH_HIGH  = 2'd1;
  localparam logic [1:0] PH_HOLD  = 2'd2;

endpackage

// File: rtl/ro_edge_counter.sv
// Synchronises ro_in, detects rising edges and counts them while enabled.
// RO_MEAS_SATURATE_EN: saturate at all-ones and flag overflow instead of wrapping.
module ro_edge_counter #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ro,
  input  logic             i_en,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt_nxt,
  output logic             o_ovf_nxt
);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_sync3;
  logic [CNT_W-1:0] r_cnt;
  logic             w_inc;

  assign w_inc = i_en & r_sync2 & ~r_sync3;

`ifdef RO_MEAS_SATURATE_EN
  logic r_ovf;
  logic w_at_max;

  assign w_at_max = &r_cnt;

  always_comb begin
    o_cnt_nxt = r_cnt;
    o_ovf_nxt = r_ovf;
    if (i_clr) begin
      o_cnt_nxt = '0;
      o_ovf_nxt = 1'b0;
    end else if (w_inc) begin
      if (w_at_max) o_ovf_nxt = 1'b1;
      else          o_cnt_nxt = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_ovf <= 1'b0;
    else       r_ovf <= o_ovf_nxt;
  end
`else
  always_comb begin
    o_cnt_nxt = r_cnt;
    o_ovf_nxt = 1'b0;
    if (i_clr)      o_cnt_nxt = '0;
    else if (w_inc) o_cnt_nxt = r_cnt + 1'b1;
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_ro;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_cnt   <= o_cnt_nxt;
    end
  end

endmodule

// File: rtl/ro_meas_ctrl.sv
// Ring-oscillator measurement sequencer: chain load, settle, windowed edge count, handshake.
// RO_MEAS_SATURATE_EN selects a saturating counter with overflow flag.
//
// state      | meaning
// IDLE       | waiting for start; ro_rst asserted
// LOAD       | shifting cfg_word into the chain, MSB first, 3 cycles per bit
// SETTLE     | oscillator released from reset, waiting SETTLE cycles
// MEASURE    | counting synchronised ro_in rising edges for WINDOW cycles
// DONE       | result valid, waiting for ack
module ro_meas_ctrl
  import ro_meas_pkg::*;
#(
  parameter int CFG_BITS = 12,
  parameter int SETTLE   = 8,
  parameter int WINDOW   = 64,
  parameter int CNT_W    = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [SRC_W-1:0]    i_src_sel,
  input  logic [CFG_BITS-1:0] i_cfg_word,
  input  logic                i_ro_in,
  input  logic                i_ack,
  output logic                o_shift_clk,
  output logic                o_shift_dta,
  output logic [SRC_W-1:0]    o_clk_source,
  output logic                o_ro_rst,
  output logic                o_busy,
  output logic                o_result_valid,
  output logic [CNT_W-1:0]    o_result,
  output logic                o_ovf
);

  localparam int BIT_W   = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
  localparam int TMR_MAX = (SETTLE > WINDOW) ? SETTLE : WINDOW;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  state_t              r_state;
  logic [1:0]          r_phase;
  logic [BIT_W-1:0]    r_bit;
  logic [TMR_W-1:0]    r_timer;
  logic [CFG_BITS-1:0] r_cfg;
  logic [SRC_W-1:0]    r_src;
  logic [CNT_W-1:0]    r_result;
  logic                r_ovf;

  state_t              w_state_nxt;
  logic [1:0]          w_phase_nxt;
  logic [BIT_W-1:0]    w_bit_nxt;
  logic [TMR_W-1:0]    w_timer_nxt;
  logic                w_accept;
  logic                w_capture;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_ovf_nxt;

  // Result is taken from the counter's next value so the last window cycle is included.
  ro_edge_counter #(.CNT_W(CNT_W)) u_edge_counter (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_ro      (i_ro_in),
    .i_en      (r_state == ST_MEASURE),
    .i_clr     (w_accept),
    .o_cnt_nxt (w_cnt_nxt),
    .o_ovf_nxt (w_ovf_nxt)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_phase  <= PH_SETUP;
      r_bit    <= '0;
      r_timer  <= '0;
      r_cfg    <= '0;
      r_src    <= '0;
      r_result <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_bit   <= w_bit_nxt;
      r_timer <= w_timer_nxt;
      if (w_accept) begin
        r_cfg <= i_cfg_word;
        r_src <= i_src_sel;
        r_ovf <= 1'b0;
      end
      if (w_capture) begin
        r_result <= w_cnt_nxt;
        r_ovf    <= w_ovf_nxt;
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_phase_nxt    = r_phase;
    w_bit_nxt      = r_bit;
    w_timer_nxt    = r_timer;
    w_accept       = 1'b0;
    w_capture      = 1'b0;
    o_shift_clk    = 1'b0;
    o_shift_dta    = 1'b0;
    o_ro_rst       = 1'b1;
    o_busy         = 1'b0;
    o_result_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_LOAD;
          w_phase_nxt = PH_SETUP;
          w_bit_nxt   = BIT_W'(CFG_BITS - 1);
        end
      end
      ST_LOAD: begin
        o_busy      = 1'b1;
        o_shift_dta = r_cfg[r_bit];
        o_shift_clk = (r_phase == PH_HIGH);
        if (r_phase == PH_HOLD) begin
          w_phase_nxt = PH_SETUP;
          if (r_bit == '0) begin
            w_state_nxt = ST_SETTLE;
            w_timer_nxt = TMR_W'(SETTLE - 1);
          end else begin
            w_bit_nxt = r_bit - 1'b1;
          end
        end else begin
          w_phase_nxt = r_phase + 2'd1;
        end
      end
      ST_SETTLE: begin
        o_busy   = 1'b1;
        o_ro_rst = 1'b0;
        if (r_timer == '0) begin
          w_state_nxt = ST_MEASURE;
          w_timer_nxt = TMR_W'(WINDOW - 1);
        end else begin
          w_timer_nxt = r_timer - 1'b1;
        end
      end
      ST_MEASURE: begin
        o_busy   = 1'b1;
        o_ro_rst = 1'b0;
        if (r_timer == '0) begin
          w_state_nxt = ST_DONE;
          w_capture   = 1'b1;
        end else begin
          w_timer_nxt = r_timer - 1'b1;
        end
      end
      ST_DONE: begin
        o_result_valid = 1'b1;
        if (i_ack) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_clk_source = r_src;
  assign o_result     = r_result;
  assign o_ovf        = r_ovf;

endmodule

// File: tb/tb_ro_meas_ctrl.sv
// Directed bench for ro_meas_ctrl: default instance plus a 4-bit counter instance.
module tb_ro_meas_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        ack = 1'b0;
  logic [2:0]  src_sel = 3'd0;
  logic [11:0] cfg_word = 12'd0;
  logic        ro_in = 1'b0;

  logic        shift_clk, shift_dta, ro_rst, busy, result_valid, ovf;
  logic [2:0]  clk_source;
  logic [15:0] result;

  logic        start4 = 1'b0;
  logic        ack4 = 1'b0;
  logic        shift_clk4, shift_dta4, ro_rst4, busy4, result_valid4, ovf4;
  logic [2:0]  clk_source4;
  logic [3:0]  result4;

  int          n_checks = 0;
  int          n_fail = 0;
  int          ro_period = 0;
  int          ro_ph = 0;
  logic [11:0] chain = 12'd0;
  int          n_shift = 0;

  ro_meas_ctrl u_dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_src_sel(src_sel),
    .i_cfg_word(cfg_word), .i_ro_in(ro_in), .i_ack(ack),
    .o_shift_clk(shift_clk), .o_shift_dta(shift_dta), .o_clk_source(clk_source),
    .o_ro_rst(ro_rst), .o_busy(busy), .o_result_valid(result_valid),
    .o_result(result), .o_ovf(ovf)
  );

  ro_meas_ctrl #(.CNT_W(4)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .i_start(start4), .i_src_sel(3'd6),
    .i_cfg_word(12'h0F0), .i_ro_in(ro_in), .i_ack(ack4),
    .o_shift_clk(shift_clk4), .o_shift_dta(shift_dta4), .o_clk_source(clk_source4),
    .o_ro_rst(ro_rst4), .o_busy(busy4), .o_result_valid(result_valid4),
    .o_result(result4), .o_ovf(ovf4)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ro_period == 0) begin
      ro_in = 1'b0;
      ro_ph = 0;
    end else begin
      ro_ph = (ro_ph + 1) % ro_period;
      ro_in = (ro_ph < ro_period / 2);
    end
  end

  // Reference model of the external config chain.
  always @(posedge shift_clk) begin
    chain   = {chain[10:0], shift_dta};
    n_shift = n_shift + 1;
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (ro_rst !== 1'b1) begin n_fail++; $display("FAIL reset_ro_rst got=%b exp=1", ro_rst); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", result_valid); end
    n_checks++; if (result !== 16'd0) begin n_fail++; $display("FAIL reset_result got=%0d exp=0", result); end
    n_checks++; if (shift_clk !== 1'b0) begin n_fail++; $display("FAIL reset_shift_clk got=%b exp=0", shift_clk); end
    n_checks++; if (clk_source !== 3'd0) begin n_fail++; $display("FAIL reset_clk_source got=%0d exp=0", clk_source); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load_measure();
    ro_period = 8;
    @(negedge clk);
    chain = 12'd0; n_shift = 0;
    cfg_word = 12'hA5C; src_sel = 3'd3; start = 1'b1;
    for (int k = 1; k <= 109; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 1) begin
        n_checks++; if (clk_source !== 3'd3) begin n_fail++; $display("FAIL lm_clk_source got=%0d exp=3", clk_source); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL lm_busy got=%b exp=1", busy); end
      end
      if (k == 36) begin
        n_checks++; if (ro_rst !== 1'b1) begin n_fail++; $display("FAIL lm_ro_rst_36 got=%b exp=1", ro_rst); end
      end
      if (k == 37) begin
        n_checks++; if (ro_rst !== 1'b0) begin n_fail++; $display("FAIL lm_ro_rst_37 got=%b exp=0", ro_rst); end
        n_checks++; if (n_shift !== 12) begin n_fail++; $display("FAIL lm_shift_count got=%0d exp=12", n_shift); end
        n_checks++; if (chain !== 12'hA5C) begin n_fail++; $display("FAIL lm_chain got=%h exp=a5c", chain); end
      end
      if (k == 108) begin
        n_checks++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL lm_valid_early got=%b exp=0", result_valid); end
      end
    end
    n_checks++; if (result_valid !== 1'b1) begin n_fail++; $display("FAIL lm_valid_109 got=%b exp=1", result_valid); end
    n_checks++; if (result !== 16'd8) begin n_fail++; $display("FAIL lm_result got=%0d exp=8", result); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL lm_ovf got=%b exp=0", ovf); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL lm_busy_done got=%b exp=0", busy); end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n_checks++;
      if (result_valid !== 1'b1 || result !== 16'd8) begin
        n_fail++; $display("FAIL lm_hold cyc=%0d valid=%b result=%0d exp valid=1 result=8", k, result_valid, result);
      end
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    n_checks++; if (result_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL lm_ack_idle valid=%b busy=%b exp 0/0", result_valid, busy); end
  endtask

  task automatic test_zero_and_ignore();
    ro_period = 0;
    repeat (4) @(negedge clk);
    cfg_word = 12'h3C3; src_sel = 3'd5; start = 1'b1;
    for (int k = 1; k <= 109; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 60) begin start = 1'b1; src_sel = 3'd2; end
      if (k == 61) begin
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL zi_busy_after_start got=%b exp=1", busy); end
        n_checks++; if (clk_source !== 3'd5) begin n_fail++; $display("FAIL zi_clk_source got=%0d exp=5", clk_source); end
      end
    end
    n_checks++; if (result_valid !== 1'b1) begin n_fail++; $display("FAIL zi_valid got=%b exp=1", result_valid); end
    n_checks++; if (result !== 16'd0) begin n_fail++; $display("FAIL zi_result got=%0d exp=0", result); end
    start = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (result_valid !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL zi_start_in_done valid=%b busy=%b exp 1/0", result_valid, busy); end
    ack = 1'b1;
    @(negedge clk);
    start = 1'b0; ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (busy !== 1'b0 || result_valid !== 1'b0) begin
        n_fail++; $display("FAIL zi_ack_wins cyc=%0d busy=%b valid=%b exp 0/0", k, busy, result_valid);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_overflow();
    ro_period = 4;
    @(negedge clk);
    start4 = 1'b1;
    for (int k = 1; k <= 109; k++) begin
      @(negedge clk);
      start4 = 1'b0;
      if (k == 50) begin
        n_checks++; if (busy4 !== 1'b1 || ro_rst4 !== 1'b0) begin n_fail++; $display("FAIL ov_measuring busy=%b ro_rst=%b exp 1/0", busy4, ro_rst4); end
      end
    end
    n_checks++; if (result_valid4 !== 1'b1) begin n_fail++; $display("FAIL ov_valid got=%b exp=1", result_valid4); end
    n_checks++; if (clk_source4 !== 3'd6) begin n_fail++; $display("FAIL ov_clk_source got=%0d exp=6", clk_source4); end
    n_checks++; if (shift_clk4 !== 1'b0 || shift_dta4 !== 1'b0) begin n_fail++; $display("FAIL ov_shift_idle clk=%b dta=%b exp 0/0", shift_clk4, shift_dta4); end
`ifdef RO_MEAS_SATURATE_EN
    n_checks++; if (result4 !== 4'd15) begin n_fail++; $display("FAIL ov_result got=%0d exp=15", result4); end
    n_checks++; if (ovf4 !== 1'b1) begin n_fail++; $display("FAIL ov_flag got=%b exp=1", ovf4); end
`else
    n_checks++; if (result4 !== 4'd0) begin n_fail++; $display("FAIL ov_result got=%0d exp=0", result4); end
    n_checks++; if (ovf4 !== 1'b0) begin n_fail++; $display("FAIL ov_flag got=%b exp=0", ovf4); end
`endif
    ack4 = 1'b1;
    @(negedge clk);
    ack4 = 1'b0;
    n_checks++; if (result_valid4 !== 1'b0) begin n_fail++; $display("FAIL ov_ack got=%b exp=0", result_valid4); end
    ro_period = 0;
  endtask

  task automatic test_reset_abort();
    int  hits;
    bit  found;
    bit  done_seen;
    hits = 0; found = 1'b0; done_seen = 1'b0;
    @(negedge clk);
    cfg_word = 12'hFFF; src_sel = 3'd1; start = 1'b1;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (shift_clk === 1'b1) begin
        hits++;
        if (hits == 7) found = 1'b1;
      end
    end
    n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL ra_bit5_timeout pulses=%0d exp=7", hits); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (shift_clk !== 1'b0) begin n_fail++; $display("FAIL ra_shift_clk got=%b exp=0", shift_clk); end
    n_checks++; if (ro_rst !== 1'b1) begin n_fail++; $display("FAIL ra_ro_rst got=%b exp=1", ro_rst); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ra_busy got=%b exp=0", busy); end
    @(negedge clk);
    chain = 12'd0; n_shift = 0;
    cfg_word = 12'h001; src_sel = 3'd4; start = 1'b1;
    for (int k = 1; k <= 37; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    n_checks++; if (n_shift !== 12) begin n_fail++; $display("FAIL ra_shift_count got=%0d exp=12", n_shift); end
    n_checks++; if (chain !== 12'h001) begin n_fail++; $display("FAIL ra_chain got=%h exp=001", chain); end
    for (int k = 0; k < 100 && !done_seen; k++) begin
      @(negedge clk);
      if (result_valid === 1'b1) done_seen = 1'b1;
    end
    n_checks++; if (done_seen !== 1'b1) begin n_fail++; $display("FAIL ra_done_timeout valid=%b exp=1", result_valid); end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_measure();
    test_zero_and_ignore();
    test_overflow();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
